// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: forward-select and FSM-state enums plus the register index width,
// imported by hazard_unit and hazard_fwd_sel.
// Ports: none (package).

package hazard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - E-stage operand forward select for one source operand
//
// Purpose: picks the M ALU result, the W result or the register file for one
// E-stage source register. Compiled only when FORWARDING_EN is defined.
// Ports:
//   rs                  source register of the E-stage operand
//   rdm, rdw            destination registers in M and W
//   regwritem/regwritew write enables of the M and W instructions
//   sel                 forward select (FWD_M has priority over FWD_W)

`ifdef FORWARDING_EN
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rdm,
  input  logic [REG_AW-1:0] rdw,
  input  logic              regwritem,
  input  logic              regwritew,
  output fwd_sel_e          sel
);

  // x0 is hard-wired zero, so a write to it is never a forwarding source.
  always_comb begin
    sel = FWD_RF;
    if (regwritem && (rdm != '0) && (rdm == rs)) begin
      sel = FWD_M;
    end else if (regwritew && (rdw != '0) && (rdw == rs)) begin
      sel = FWD_W;
    end
  end

endmodule
`endif

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - 5-stage pipeline hazard controller (stall/flush/forward)
//
// Purpose: load-use / RAW stalls, taken-branch flushes, freeze while a data
// memory access is outstanding, saturating stall/flush counters and a sticky
// memory timeout flag.
// Build option: FORWARDING_EN enables E-stage forwarding (only load-use stalls);
// without it, RAW hazards against E and M stall and forwarding is tied off.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   Rs1D/Rs2D, Rs1E/Rs2E           source registers in D and E
//   RdE/RdM/RdW, RegWrite{E,M,W}   destinations and write enables
//   LoadE, PCSrcE                  load in E, taken branch resolved in E
//   MemReqM, MemReadyM             data memory request / completion in M
//   Stall{F,D,E,M}, Flush{D,E,W}   pipeline register controls
//   ForwardAE/ForwardBE            operand forward selects
//   StallCount/FlushCount, MemErr  performance counters, sticky timeout flag

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [31:0]       StallCount,
  output logic [31:0]       FlushCount,
  output logic              MemErr
);

  localparam int              WW        = $clog2(MEM_TIMEOUT + 1);
  // Last wait-counter value before the timeout edge: leaving on this edge
  // makes exactly MEM_TIMEOUT cycles spent in MEMWAIT.
  localparam logic [WW-1:0]   WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  hz_state_e     state;
  logic [WW-1:0] wait_cnt;
  logic          freeze;
  logic          hz_stall;
  fwd_sel_e      fwd_a;
  fwd_sel_e      fwd_b;

  // The first stalled cycle is still in RUN, so the freeze is also raised
  // combinationally from the request; once MemReadyM rises the freeze drops
  // in the same cycle, giving exactly N frozen cycles for N wait cycles.
  assign freeze = !MemReadyM && (MemReqM || (state == MEMWAIT));

`ifdef FORWARDING_EN
  hazard_fwd_sel u_fwd_a (
    .rs        (Rs1E),
    .rdm       (RdM),
    .rdw       (RdW),
    .regwritem (RegWriteM),
    .regwritew (RegWriteW),
    .sel       (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs        (Rs2E),
    .rdm       (RdM),
    .rdw       (RdW),
    .regwritem (RegWriteM),
    .regwritew (RegWriteW),
    .sel       (fwd_b)
  );

  // Load data is only available after M, so a dependent D instruction waits once.
  assign hz_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  logic unused_fwd;
  assign unused_fwd = RegWriteE;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  // Without forwarding, any pending write in E or M blocks the reader in D;
  // W is covered by the register file's write-before-read.
  assign hz_stall = (RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
                    (RegWriteM && (RdM != '0) && ((RdM == Rs1D) || (RdM == Rs2D)));

  logic unused_nofwd;
  assign unused_nofwd = ^{LoadE, Rs1E, Rs2E, RdW, RegWriteW};
`endif

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (freeze) begin
        // PCSrcE stays held in E, so the branch flush is simply deferred.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = hz_stall;
        StallD = hz_stall;
        FlushD = PCSrcE;
        FlushE = hz_stall | PCSrcE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      MemErr     <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (MemReqM && !MemReadyM) begin
            state <= MEMWAIT;
          end
        end
        MEMWAIT: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (MemReadyM) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= RUN;
            MemErr <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase

      if (StallD && (StallCount != '1)) begin
        StallCount <= StallCount + 32'd1;
      end
      if ((FlushD || FlushE) && (FlushCount != '1)) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed table-driven bench for hazard_unit

module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] StallCount, FlushCount;
  logic       MemErr;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteE  (RegWriteE),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .LoadE      (LoadE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallCount (StallCount),
    .FlushCount (FlushCount),
    .MemErr     (MemErr)
  );

  // ctl = {RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM}
  // st  = {StallF, StallD, StallE, StallM}, fl = {FlushD, FlushE, FlushW}
  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [6:0] ctl;
    logic [3:0] st;
    logic [2:0] fl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;
  int   exp_sc = 0;
  int   exp_fc = 0;

  task automatic add(input string n, input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                     input logic [6:0] ctl, input logic [3:0] st, input logic [2:0] fl,
                     input logic [1:0] fa, fb);
    vec_t v;
    v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.ctl = ctl;
    v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s.%s: got %0h expected %0h", name, what, act, exp);
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  task automatic apply(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    {RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = v.ctl;
  endtask

  task automatic chk_outs(input string name, input logic [3:0] st, input logic [2:0] fl,
                          input logic [1:0] fa, fb);
    chk(name, "stall", {StallF, StallD, StallE, StallM}, st);
    chk(name, "flush", {FlushD, FlushE, FlushW}, fl);
    chk(name, "fwdA", ForwardAE, fa);
    chk(name, "fwdB", ForwardBE, fb);
  endtask

  // Inputs are already driven (posedge+1); sample at negedge, account the
  // expected counter effect, then move to the next posedge+1.
  task automatic cyc_check(input string name, input logic [3:0] st, input logic [2:0] fl,
                           input logic [1:0] fa, fb);
    @(negedge clk);
    chk_outs(name, st, fl, fa, fb);
    exp_sc += int'(st[2]);
    exp_fc += int'(fl[2] | fl[1]);
    @(posedge clk); #1;
  endtask

  task automatic chk_cnt(input string name);
    chk(name, "StallCount", StallCount, exp_sc);
    chk(name, "FlushCount", FlushCount, exp_fc);
  endtask

  initial begin
    // common vectors: same expectations in both builds
    add("idle",        0, 0, 0, 0, 0, 0, 0, 7'b0000000, 4'b0000, 3'b000, 2'b00, 2'b00);
    add("loaduse_rs1", 5, 0, 0, 0, 5, 0, 0, 7'b1001000, 4'b1100, 3'b010, 2'b00, 2'b00);
    add("loaduse_rs2", 0, 5, 0, 0, 5, 0, 0, 7'b1001000, 4'b1100, 3'b010, 2'b00, 2'b00);
    add("load_x0",     0, 0, 0, 0, 0, 0, 0, 7'b1001000, 4'b0000, 3'b000, 2'b00, 2'b00);
    add("load_nomatch",6, 7, 0, 0, 5, 0, 0, 7'b1001000, 4'b0000, 3'b000, 2'b00, 2'b00);
    add("branch",      0, 0, 0, 0, 0, 0, 0, 7'b0000100, 4'b0000, 3'b110, 2'b00, 2'b00);
    add("branch_lw",   5, 0, 0, 0, 5, 0, 0, 7'b1001100, 4'b1100, 3'b110, 2'b00, 2'b00);
    add("freeze_comb", 5, 0, 0, 0, 5, 0, 0, 7'b1001110, 4'b1111, 3'b001, 2'b00, 2'b00);
    add("mem_done",    0, 0, 0, 0, 0, 0, 0, 7'b0000011, 4'b0000, 3'b000, 2'b00, 2'b00);
    add("mem_hit",     0, 0, 0, 0, 0, 0, 0, 7'b0000011, 4'b0000, 3'b000, 2'b00, 2'b00);
`ifdef FORWARDING_EN
    add("fwd_m_pri",   0, 0, 7, 0, 0, 7, 7, 7'b0110000, 4'b0000, 3'b000, 2'b10, 2'b00);
    add("fwd_w",       0, 0, 7, 0, 0, 7, 7, 7'b0010000, 4'b0000, 3'b000, 2'b01, 2'b00);
    add("fwd_x0",      0, 0, 0, 0, 0, 0, 0, 7'b0110000, 4'b0000, 3'b000, 2'b00, 2'b00);
    add("fwd_b_m",     0, 0, 0, 9, 0, 9, 4, 7'b0110000, 4'b0000, 3'b000, 2'b00, 2'b10);
    add("fwd_no_raw",  0, 3, 0, 0, 0, 3, 0, 7'b0100000, 4'b0000, 3'b000, 2'b00, 2'b00);
`else
    add("raw_m_rs2",   0, 3, 0, 0, 0, 3, 0, 7'b0100000, 4'b1100, 3'b010, 2'b00, 2'b00);
    add("raw_e_rs1",   4, 0, 0, 0, 4, 0, 0, 7'b1000000, 4'b1100, 3'b010, 2'b00, 2'b00);
    add("raw_w_none",  3, 0, 0, 0, 0, 0, 3, 7'b0010000, 4'b0000, 3'b000, 2'b00, 2'b00);
    add("raw_m_x0",    0, 0, 0, 0, 0, 0, 0, 7'b0100000, 4'b0000, 3'b000, 2'b00, 2'b00);
    add("raw_e_nowr",  4, 0, 0, 0, 4, 0, 0, 7'b0000000, 4'b0000, 3'b000, 2'b00, 2'b00);
    add("nofwd_zero",  1, 0, 7, 7, 0, 7, 7, 7'b0110000, 4'b0000, 3'b000, 2'b00, 2'b00);
`endif

    // reset state, including with hazard inputs active while rst is high
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 4'b0000, 3'b111, 2'b00, 2'b00);
    chk("reset", "MemErr", MemErr, 0);
    chk_cnt("reset");
    Rs1D = 5; RdE = 5; LoadE = 1; RegWriteE = 1; PCSrcE = 1; MemReqM = 1;
    RegWriteM = 1; RdM = 7; Rs1E = 7; Rs2D = 7;
    #2;
    chk_outs("reset_busy", 4'b0000, 3'b111, 2'b00, 2'b00);
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      cyc_check(vecs[i].name, vecs[i].st, vecs[i].fl, vecs[i].fa, vecs[i].fb);
      chk_cnt(vecs[i].name);
    end
    clear_inputs();
    cyc_check("table_idle", 4'b0000, 3'b000, 2'b00, 2'b00);

    // three wait cycles freeze for exactly three cycles
    MemReqM = 1; MemReadyM = 0;
    repeat (3) cyc_check("memwait3", 4'b1111, 3'b001, 2'b00, 2'b00);
    MemReadyM = 1;
    cyc_check("mem_release", 4'b0000, 3'b000, 2'b00, 2'b00);
    MemReqM = 0; MemReadyM = 0;
    cyc_check("mem_after", 4'b0000, 3'b000, 2'b00, 2'b00);

    // branch held during the wait: flush deferred to the release cycle
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    repeat (3) cyc_check("memwait_br", 4'b1111, 3'b001, 2'b00, 2'b00);
    MemReadyM = 1;
    cyc_check("br_release", 4'b0000, 3'b110, 2'b00, 2'b00);
    clear_inputs();
    cyc_check("br_after", 4'b0000, 3'b000, 2'b00, 2'b00);
    chk_cnt("after_memwait");

    // timeout: one RUN freeze cycle plus four MEMWAIT cycles
    chk("timeout_pre", "MemErr", MemErr, 0);
    MemReqM = 1; MemReadyM = 0;
    repeat (4) cyc_check("timeout_wait", 4'b1111, 3'b001, 2'b00, 2'b00);
    chk("timeout_early", "MemErr", MemErr, 0);
    cyc_check("timeout_last", 4'b1111, 3'b001, 2'b00, 2'b00);
    chk("timeout_set", "MemErr", MemErr, 1);
    MemReqM = 0;
    cyc_check("timeout_run", 4'b0000, 3'b000, 2'b00, 2'b00);
    cyc_check("timeout_idle", 4'b0000, 3'b000, 2'b00, 2'b00);
    chk("timeout_sticky", "MemErr", MemErr, 1);
    chk_cnt("after_timeout");

    // asynchronous reset in the middle of a wait
    MemReqM = 1; MemReadyM = 0;
    repeat (2) cyc_check("pre_rst_wait", 4'b1111, 3'b001, 2'b00, 2'b00);
    #1 rst = 1'b1;
    #1;
    chk_outs("rst_midwait", 4'b0000, 3'b111, 2'b00, 2'b00);
    chk("rst_midwait", "MemErr", MemErr, 0);
    exp_sc = 0; exp_fc = 0;
    chk_cnt("rst_midwait");
    @(posedge clk); #1;
    rst = 1'b0; MemReqM = 0;
    cyc_check("post_rst_run", 4'b0000, 3'b000, 2'b00, 2'b00);
    chk("post_rst", "MemErr", MemErr, 0);
    chk_cnt("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. Drives the Stall/Flush inputs of the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand forwarding muxes. It detects load-use and RAW hazards, flushes on taken branches and freezes the pipeline while a multi-cycle data-memory access is outstanding. It also keeps saturating stall and flush performance counters and a sticky memory-timeout error.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive MEMWAIT cycles before MemErr sets; legal range is 1..65535.
- clk  in  1  core clock. State updates on posedge; pipeline registers sample on negedge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers of the D-stage instruction.
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the E-stage instruction.
- RdM, RdW  in  5  destination registers in M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  write-enable of the instruction in each stage.
- LoadE  in  1  the E-stage instruction is a load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MemReqM  in  1  the M-stage instruction accesses data memory this cycle.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold PC, F/D, D/E and E/M.
- FlushD, FlushE, FlushW  out  1  bubble into F/D, D/E and M/W.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 W result, 10 M ALU result.
- StallCount, FlushCount  out  32  performance counters.
- MemErr  out  1  sticky flag: a memory access exceeded MEM_TIMEOUT cycles.

## Operation
- FSM has two states: RUN and MEMWAIT. Reset state is RUN.
- RUN to MEMWAIT: when MemReqM=1 and MemReadyM=0 at posedge.
- MEMWAIT to RUN: when MemReadyM=1, or when the wait counter reaches MEM_TIMEOUT.
  - On timeout, MemErr sets to 1 and stays set until rst.
- Memory freeze applies in MEMWAIT, and also combinationally in RUN whenever MemReqM=1 and MemReadyM=0:
  - StallF=StallD=StallE=StallM=1 and FlushW=1.
  - FlushD=FlushE=0.
  - The freeze overrides load-use and branch logic. PCSrcE stays held in E, so its flush happens on the first unfrozen cycle.
- Load-use hazard (lwStall): LoadE=1, RdE≠0, and RdE==Rs1D or RdE==Rs2D.
- Outside a freeze:
  - StallF=StallD=lwStall.
  - FlushD=PCSrcE.
  - FlushE=lwStall|PCSrcE.
  - StallE=StallM=FlushW=0.
- Forwarding, per operand (A uses Rs1E, B uses Rs2E):
  - 10 if RegWriteM=1, RdM≠0 and RdM==RsE.
  - Otherwise 01 if RegWriteW=1, RdW≠0 and RdW==RsE.
  - Otherwise 00.
  - M has priority over W.
- x0 never creates a hazard or a forward.
- StallCount increments at each posedge where StallD=1.
- FlushCount increments at each posedge where FlushD|FlushE=1.
- Both counters saturate at 0xFFFFFFFF.
- The wait counter is $clog2(MEM_TIMEOUT+1) bits wide. It clears in RUN and increments each cycle in MEMWAIT.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and state, and settle before the negedge sample.
- While rst=1:
  - FlushD=FlushE=FlushW=1.
  - All stalls are 0 and Forward* are 00.
  - Counters, wait counter and MemErr are 0, and state is RUN.
- Load-use costs exactly one bubble.
- A taken branch costs two bubbles.
- A memory access with N wait cycles (MemReadyM low for N cycles) freezes for N cycles.
- Simultaneous lwStall and PCSrcE: the branch wins because the D instruction is flushed. StallF/StallD still assert, which is harmless since the F/D content is flushed.
- rst asserted mid-MEMWAIT returns the FSM to RUN immediately (asynchronous).

## Configuration
- FORWARDING_EN defined:
  - Forwarding is as described above.
  - Only load-use stalls are generated.
- FORWARDING_EN undefined:
  - ForwardAE=ForwardBE=00 always.
  - lwStall is replaced by rawStall. rawStall=1 when, for E or M, RegWrite=1, Rd≠0 and Rd matches Rs1D or Rs2D.
  - W needs no stall because the register file resolves write-before-read.
  - StallF=StallD=rawStall and FlushE=rawStall|PCSrcE.

## Structure
- Package hazard_pkg holds:
  - enum fwd_sel_e: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - enum hz_state_e: RUN, MEMWAIT.
  - The register-index width constant REG_AW=5.
- Sub-module hazard_fwd_sel computes one operand's forward select. It is instantiated twice, for A and B, and is compiled only under FORWARDING_EN.

## Test plan
- Load-use: LoadE=1, RdE=5, Rs1D=5 → StallF=StallD=FlushE=1 for one cycle; StallCount increments by 1.
- Branch: PCSrcE=1 with no other hazard → FlushD=FlushE=1, stalls 0; FlushCount increments by 1.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles → all four stalls and FlushW=1 for exactly 3 cycles; release on MemReadyM=1. Repeat with PCSrcE=1 held during the wait → flush deferred until release.
- Forward priority: RdM=RdW=Rs1E=7, RegWriteM=RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Set Rd=0 → 00.
- Timeout: MEM_TIMEOUT=4, MemReadyM held low → MemErr=1 after the 4th MEMWAIT cycle and FSM returns to RUN. Assert rst mid-wait → all state cleared and flushes asserted while rst=1.
- No-forwarding build: RegWriteM=1, RdM=3, Rs2D=3 → StallD=FlushE=1 and Forward*=00.
